// File: rtl/lookahead_counter.sv
// Registered up/down counter with a grouped carry-lookahead adder, carry/borrow flag,
// optional saturation and auto-reload in wrap mode.
module lookahead_counter #(
  parameter int WIDTH    = 16,
  parameter int GROUP    = 4,
  parameter int SATURATE = 0
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] LDVAL,
  input  logic             EN,
  input  logic             DN,
  input  logic [WIDTH-1:0] STEP,
  input  logic             ARL,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  localparam int NGRP = WIDTH / GROUP;
  localparam bit SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] nand_t;
  logic [WIDTH-1:0] nor_t;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  // Generate/propagate over bits [hi-1:0] of one group, returned as {G, P}.
  function automatic logic [1:0] span_gp(input logic [GROUP-1:0] g,
                                         input logic [GROUP-1:0] p,
                                         input int hi);
    logic acc;
    logic run;
    acc = 1'b0;
    run = 1'b1;
    for (int k = GROUP - 1; k >= 0; k--) begin
      if (k < hi) begin
        acc = acc | (g[k] & run);
        run = run & p[k];
      end
    end
    return {acc, run};
  endfunction

  // Subtraction is Q + ~STEP + 1, with the +1 entering as the carry-in.
  assign opb    = DN ? ~STEP : STEP;
  assign nand_t = ~(Q & opb);
  assign nor_t  = ~(Q | opb);
  assign gen    = ~nand_t;
  assign prop   = ~nor_t;
  assign half   = Q ^ opb;

  for (genvar gi = 0; gi < NGRP; gi++) begin : grp
    logic [GROUP-1:0] g_l;
    logic [GROUP-1:0] p_l;
    logic [GROUP-1:0] c_l;
    logic [1:0]       gp_all;
    logic             cin;
    logic             cout;

    assign g_l    = gen[gi*GROUP +: GROUP];
    assign p_l    = prop[gi*GROUP +: GROUP];
    assign gp_all = span_gp(g_l, p_l, GROUP);

    if (gi == 0) begin : first
      assign cin = DN;
    end else begin : chain
      assign cin = grp[gi-1].cout;
    end

    always_comb begin
      logic [1:0] gp;
      gp  = 2'b00;
      c_l = '0;
      for (int j = 0; j < GROUP; j++) begin
        gp     = span_gp(g_l, p_l, j);
        c_l[j] = gp[1] | (gp[0] & cin);
      end
    end

    assign sum[gi*GROUP +: GROUP] = half[gi*GROUP +: GROUP] ^ c_l;
    assign cout                   = gp_all[1] | (gp_all[0] & cin);
  end

  assign carry = grp[NGRP-1].cout;
  assign ovf   = DN ? ~carry : carry;

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      Q  <= '0;
      CO <= 1'b0;
    end else if (CLR) begin
      Q  <= '0;
      CO <= 1'b0;
    end else if (LD) begin
      Q  <= LDVAL;
      CO <= 1'b0;
    end else if (EN) begin
      if (!ovf) begin
        Q  <= sum;
        CO <= 1'b0;
      end else begin
        CO <= 1'b1;
        if (SAT) begin
          Q <= DN ? '0 : '1;
        end else if (ARL) begin
          Q <= LDVAL;
        end else begin
          Q <= sum;
        end
      end
    end else begin
      CO <= 1'b0;
    end
  end

  assign ZERO = (Q == '0);

endmodule
